booth_datapath: RTL and testbench
=================================

// Module: booth_datapath
// PURPOSE
//   Radix-2 Booth datapath for the sequential multiplier. Sits directly under the multiplier FSM.
//   Consumes the FSM strobes (en_mux, en_acc, en_ashr, en_count, rst_count, ready).
//   Returns the Booth pair (Qlsb, Qn) and the iteration count, and presents the signed 2*WIDTH product.
// PARAMETERS
//   WIDTH  5  operand width in bits, signed two's complement; equals the FSM WIDTH_MUL
// PORTS
//   clk            in   1        clock, rising edge
//   rst            in   1        reset, asynchronous, active-high
//   multiplicand   in   WIDTH    signed operand M
//   multiplier     in   WIDTH    signed operand Q
//   en_mux         in   1        load operands; clear accumulator and Q-1
//   en_acc         in   1        accumulate A <= A +/- M, selected by {Q0,Q-1}
//   en_ashr        in   1        arithmetic shift right of {A,Q,Q-1}
//   en_count       in   1        iteration counter +1
//   rst_count      in   1        synchronous clear of the iteration counter
//   ready          in   1        FSM done pulse, 1 cycle
//   product_ack    in   1        consumer has taken the product
//   Qlsb           out  1        Q[0] (registered)
//   Qn             out  1        Q-1 bit (registered)
//   count          out  WIDTH    iterations completed
//   product        out  2*WIDTH  signed product {A[WIDTH-1:0],Q}
//   product_valid  out  1        product is valid
// BEHAVIOUR
//   - Registers: M[WIDTH-1:0], A[WIDTH:0] (one guard bit), Q[WIDTH-1:0], q_m1, cnt[WIDTH-1:0].
//   - Guard bit: A+M and A-M cannot overflow, including M = -2^(WIDTH-1).
//   - Reset: all registers, product and product_valid = 0. Asserting rst mid-operation clears everything immediately.
//   - Strobe priority in one cycle: en_mux > en_acc > en_ashr. rst_count and en_count are independent; rst_count wins over en_count.
//   - en_mux: M <= multiplicand, Q <= multiplier, A <= 0, q_m1 <= 0.
//   - en_mux while the FSM is in INIT: operands re-sampled every cycle; the last INIT cycle's values are used.
//   - en_acc, {Q[0],q_m1}=01: A <= A + sext(M).
//   - en_acc, {Q[0],q_m1}=10: A <= A - sext(M).
//   - en_acc, {Q[0],q_m1}=00 or 11: A unchanged.
//   - en_ashr: {A,Q,q_m1} <= {A[WIDTH],A,Q} >> 1. A[WIDTH] replicates; the old Q[0] goes to q_m1.
//   - en_count: cnt <= cnt+1, wraps modulo 2^WIDTH. Not saturated; the FSM stops at WIDTH.
//   - Qlsb = Q[0], Qn = q_m1, count = cnt: register outputs, updated one clk after the strobe.
//   - Latency: the FSM sees the new pair in the cycle after en_ashr. FSM WAIT covers this.
//   - Product = {A[WIDTH-1:0],Q} after WIDTH shifts. It equals the exact signed product for all operand pairs.
// CONFIGURATION
//   BOOTH_DP_PROD_REG_EN defined:
//     - On ready, product <= {A[WIDTH-1:0],Q} and product_valid <= 1.
//     - product and product_valid hold until a cycle with product_ack=1; that cycle clears product_valid, product is held.
//     - ready with product_ack in the same cycle: capture wins, product_valid stays 1.
//     - en_mux does not disturb product or product_valid (the next multiply overlaps consumption).
//   BOOTH_DP_PROD_REG_EN undefined:
//     - product = {A[WIDTH-1:0],Q} combinationally; valid only while ready=1.
//     - product_valid = ready, a 1-cycle pulse; product_ack is ignored.
// TESTING (WIDTH=5; strobes driven in FSM order, or the FSM instantiated alongside)
//   - 3 x -4: en_mux with multiplicand=5'd3, multiplier=5'b11100 -> Qlsb=0, Qn=0, count=0. After 5 iterations product=10'h3F4 on ready.
//   - -16 x -16: product=10'h100. Checks the guard bit on A - M with M=-16.
//   - 15 x 15 -> product=10'h0E1; 0 x -7 -> product=10'h000; -1 x 1 -> product=10'h3FF.
//   - en_count over 32 pulses -> count wraps 31->0. rst_count with en_count together -> count=0.
//   - PROD_REG_EN, product_valid:
//     - ack held 0 -> product_valid stays 1 for 10 cycles with product stable.
//     - ack=1 -> product_valid=0 next cycle.
//     - ready and ack together -> product_valid=1 with the new value.
//   - rst mid-iteration (count=2): all outputs 0 in the same cycle. A fresh 3 x -4 then yields 10'h3F4.

Source files
------------

// File: rtl/booth_datapath.sv
// Radix-2 Booth datapath under the sequential multiplier FSM: operand, accumulator, shift and count registers.
// Define BOOTH_DP_PROD_REG_EN to register the product behind a valid/ack handshake; otherwise it is combinational.
module booth_datapath #(
  parameter int WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               en_mux,
  input  logic               en_acc,
  input  logic               en_ashr,
  input  logic               en_count,
  input  logic               rst_count,
  input  logic               ready,
  input  logic               product_ack,
  output logic               Qlsb,
  output logic               Qn,
  output logic [WIDTH-1:0]   count,
  output logic [2*WIDTH-1:0] product,
  output logic               product_valid
);

  logic [WIDTH-1:0]   m_reg;
  logic [WIDTH:0]     a_reg;
  logic [WIDTH-1:0]   q_reg;
  logic               q_m1;
  logic [WIDTH-1:0]   cnt;

  logic [WIDTH-1:0]   m_next;
  logic [WIDTH:0]     a_next;
  logic [WIDTH-1:0]   q_next;
  logic               q_m1_next;
  logic [WIDTH-1:0]   cnt_next;

  logic [WIDTH:0]     m_ext;
  logic [WIDTH:0]     a_sum;
  logic [WIDTH:0]     a_diff;
  logic [WIDTH:0]     a_acc;
  logic [2*WIDTH-1:0] product_raw;

  // The extra guard bit keeps A - M exact even for M = -2^(WIDTH-1).
  assign m_ext  = {m_reg[WIDTH-1], m_reg};
  assign a_sum  = a_reg + m_ext;
  assign a_diff = a_reg - m_ext;

  always_comb begin
    a_acc = a_reg;
    case ({q_reg[0], q_m1})
      2'b01:   a_acc = a_sum;
      2'b10:   a_acc = a_diff;
      default: a_acc = a_reg;
    endcase
  end

  always_comb begin
    m_next    = m_reg;
    a_next    = a_reg;
    q_next    = q_reg;
    q_m1_next = q_m1;
    if (en_mux) begin
      m_next    = multiplicand;
      q_next    = multiplier;
      a_next    = '0;
      q_m1_next = 1'b0;
    end else if (en_acc) begin
      a_next = a_acc;
    end else if (en_ashr) begin
      {a_next, q_next, q_m1_next} = {a_reg[WIDTH], a_reg, q_reg};
    end
  end

  always_comb begin
    cnt_next = cnt;
    if (rst_count) begin
      cnt_next = '0;
    end else if (en_count) begin
      cnt_next = cnt + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reg <= '0;
      a_reg <= '0;
      q_reg <= '0;
      q_m1  <= 1'b0;
      cnt   <= '0;
    end else begin
      m_reg <= m_next;
      a_reg <= a_next;
      q_reg <= q_next;
      q_m1  <= q_m1_next;
      cnt   <= cnt_next;
    end
  end

  assign Qlsb        = q_reg[0];
  assign Qn          = q_m1;
  assign count       = cnt;
  assign product_raw = {a_reg[WIDTH-1:0], q_reg};

`ifdef BOOTH_DP_PROD_REG_EN
  logic [2*WIDTH-1:0] prod_q;
  logic               valid_q;

  // A new capture beats a same-cycle ack so a back-to-back result is never dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
    end else if (ready) begin
      prod_q  <= product_raw;
      valid_q <= 1'b1;
    end else if (product_ack) begin
      valid_q <= 1'b0;
    end
  end

  assign product       = prod_q;
  assign product_valid = valid_q;
`else
  logic unused_ack;
  assign unused_ack    = product_ack;
  assign product       = product_raw;
  assign product_valid = ready;
`endif

endmodule

// File: tb/tb_booth_datapath.sv
// Self-checking bench for booth_datapath: directed and random multiplies against signed arithmetic.
module tb_booth_datapath;
  localparam int W = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           en_mux, en_acc, en_ashr, en_count, rst_count, ready, product_ack;
  logic           Qlsb, Qn;
  logic [W-1:0]   count;
  logic [2*W-1:0] product;
  logic           product_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  booth_datapath #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .en_mux(en_mux), .en_acc(en_acc), .en_ashr(en_ashr),
    .en_count(en_count), .rst_count(rst_count),
    .ready(ready), .product_ack(product_ack),
    .Qlsb(Qlsb), .Qn(Qn), .count(count),
    .product(product), .product_valid(product_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] m, input logic [W-1:0] q);
    int p;
    p = int'($signed(m)) * int'($signed(q));
    return p[2*W-1:0];
  endfunction

  task automatic load(input logic [W-1:0] m, input logic [W-1:0] q);
    @(negedge clk);
    multiplicand = m; multiplier = q; en_mux = 1; rst_count = 1;
    @(negedge clk);
    en_mux = 0; rst_count = 0;
    chk("load_qlsb", Qlsb, q[0]);
    chk("load_qn", Qn, 0);
    chk("load_count", count, 0);
  endtask

  // Iteration k exposes multiplier bit k as Q-1 and bit k+1 as Q0.
  task automatic iterate(input logic [W-1:0] q, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); en_acc = 1;
      @(negedge clk); en_acc = 0; en_ashr = 1; en_count = 1;
      @(negedge clk); en_ashr = 0; en_count = 0;
      chk("iter_qn", Qn, q[k]);
      chk("iter_count", count, k + 1);
      if (k + 1 < W) chk("iter_qlsb", Qlsb, q[k+1]);
    end
  endtask

  task automatic finish_mul(input logic [2*W-1:0] expv, input logic ack);
    @(negedge clk); ready = 1; product_ack = ack;
`ifdef BOOTH_DP_PROD_REG_EN
    @(negedge clk); ready = 0; product_ack = 0;
    chk("prod_valid", product_valid, 1);
    chk("product", product, expv);
`else
    #1;
    chk("prod_valid", product_valid, 1);
    chk("product", product, expv);
    @(negedge clk); ready = 0; product_ack = 0; #1;
    chk("prod_valid_low", product_valid, 0);
`endif
  endtask

  task automatic run_mul(input logic [W-1:0] m, input logic [W-1:0] q, input logic ack);
    load(m, q);
    iterate(q, W);
    finish_mul(ref_prod(m, q), ack);
  endtask

  initial begin
    logic [W-1:0]   rm, rq;
    logic [2*W-1:0] held;
    rst = 1; multiplicand = 0; multiplier = 0;
    en_mux = 0; en_acc = 0; en_ashr = 0; en_count = 0; rst_count = 0;
    ready = 0; product_ack = 0;
    #12;
    chk("rst_qlsb", Qlsb, 0);
    chk("rst_qn", Qn, 0);
    chk("rst_count", count, 0);
    chk("rst_product", product, 0);
    chk("rst_valid", product_valid, 0);
    @(negedge clk); rst = 0;

    load(5'd3, 5'b11100);
    iterate(5'b11100, W);
    finish_mul(10'h3F4, 0);
    run_mul(5'b10000, 5'b10000, 0);
    chk("neg16_sq", product, 10'h100);
    run_mul(5'd15, 5'd15, 0);
    chk("pos15_sq", product, 10'h0E1);
    run_mul(5'd0, 5'b11001, 0);
    chk("zero_x_m7", product, 10'h000);
    run_mul(5'b11111, 5'd1, 0);
    chk("m1_x_1", product, 10'h3FF);

    for (int i = 0; i < 20; i++) begin
      rm = W'($urandom_range(0, 31));
      rq = W'($urandom_range(0, 31));
      run_mul(rm, rq, 0);
    end

    @(negedge clk); rst_count = 1;
    @(negedge clk); rst_count = 0; en_count = 1;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (i == 31) chk("count_31", count, 31);
    end
    en_count = 0;
    chk("count_wrap", count, 0);
    @(negedge clk); en_count = 1;
    @(negedge clk); rst_count = 1;
    chk("count_one", count, 1);
    @(negedge clk); rst_count = 0; en_count = 0;
    chk("count_clr_wins", count, 0);

`ifdef BOOTH_DP_PROD_REG_EN
    run_mul(5'd2, 5'd3, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", product_valid, 1);
      chk("hold_product", product, 10'd6);
    end
    load(5'd5, 5'd6);
    chk("mux_keeps_valid", product_valid, 1);
    chk("mux_keeps_prod", product, 10'd6);
    iterate(5'd6, W);
    finish_mul(10'd30, 1);
    @(negedge clk); product_ack = 1;
    @(negedge clk); product_ack = 0;
    chk("ack_clears", product_valid, 0);
    chk("ack_holds_prod", product, 10'd30);
`endif

    load(5'd3, 5'b11100);
    iterate(5'b11100, 2);
    held = ref_prod(5'd3, 5'b11100);
    #2 rst = 1;
    #1;
    chk("midrst_qlsb", Qlsb, 0);
    chk("midrst_qn", Qn, 0);
    chk("midrst_count", count, 0);
    chk("midrst_product", product, 0);
    chk("midrst_valid", product_valid, 0);
    @(negedge clk); rst = 0;
    run_mul(5'd3, 5'b11100, 0);
    chk("after_rst", product, held);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
